// File: rtl/lvds_deser_align_if.sv
// Parallel-side bundle of the LVDS deserializer: serial input, resync request,
// aligned word output with its strobe and the lock indicator.
interface lvds_deser_align_if #(
  parameter int DATA_W = 8
);
  logic              lvds_in;
  logic              resync;
  logic [DATA_W-1:0] lvds_out;
  logic              out_valid;
  logic              locked;

  modport master (
    output lvds_in,
    output resync,
    input  lvds_out,
    input  out_valid,
    input  locked
  );

  modport slave (
    input  lvds_in,
    input  resync,
    output lvds_out,
    output out_valid,
    output locked
  );
endinterface

// File: rtl/lvds_deser_align.sv
// Serial-to-parallel LVDS deserializer that hunts for a sync word at any bit phase,
// locks after LOCK_CNT aligned sync words and then emits every aligned word.
//
//   state  | meaning
//   HUNT   | searching every cycle for the sync word at any bit offset
//   VERIFY | phase chosen; checking sync word at each word boundary
//   LOCKED | aligned; every completed word is emitted with out_valid
module lvds_deser_align #(
  parameter int                DATA_W    = 8,
  parameter bit                LSB_FIRST = 1'b1,
  parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(8'hA5),
  parameter int                LOCK_CNT  = 3
) (
  input  logic               lvds_clk,
  input  logic               rst_n,
  lvds_deser_align_if.slave  bus
);

  localparam int         CNT_W  = $clog2(DATA_W);
  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [3:0]        match_cnt;
  logic [DATA_W-1:0] out_q;
  logic              valid_q;
  logic              locked_q;
  logic              hit;
  logic              wc;

  generate
    if (LSB_FIRST) begin : g_lsb
      assign shift_nxt = {bus.lvds_in, shift_reg[DATA_W-1:1]};
    end else begin : g_msb
      assign shift_nxt = {shift_reg[DATA_W-2:0], bus.lvds_in};
    end
  endgenerate

  assign hit = (shift_reg == SYNC_WORD);
  assign wc  = (bit_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge lvds_clk) begin
    if (!rst_n) begin
      state     <= HUNT;
      shift_reg <= '0;
      bit_cnt   <= '0;
      match_cnt <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      shift_reg <= shift_nxt;
      bit_cnt   <= wc ? '0 : bit_cnt + CNT_W'(1);
      valid_q   <= 1'b0;
      // resync wins over any hit or word boundary seen in the same cycle
      if (bus.resync) begin
        state     <= HUNT;
        match_cnt <= '0;
        locked_q  <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            if (hit) begin
              bit_cnt   <= '0;
              match_cnt <= 4'd1;
              if (LOCK_CNT == 1) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
              end else begin
                state <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (wc) begin
              if (hit) begin
                match_cnt <= match_cnt + 4'd1;
                if (match_cnt + 4'd1 == LOCK_N) begin
                  state    <= LOCKED;
                  locked_q <= 1'b1;
                end
              end else begin
                state     <= HUNT;
                match_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if (wc) begin
              out_q   <= shift_reg;
              valid_q <= 1'b1;
            end
          end
          default: begin
            state     <= HUNT;
            match_cnt <= '0;
            locked_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.lvds_out  = out_q;
  assign bus.out_valid = valid_q;
  assign bus.locked    = locked_q;

endmodule

// File: tb/tb_lvds_deser_align.sv
// Directed bench for lvds_deser_align: three instances cover LSB-first 8-bit,
// MSB-first 8-bit and MSB-first 10-bit configurations fed from one serial stream.
module tb_lvds_deser_align;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic rsync = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   t_end;

  logic [9:0] qa_w[$];
  int         qa_t[$];
  logic [9:0] qb_w[$];
  logic [9:0] qc_w[$];
  int         qc_t[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lvds_deser_align_if #(.DATA_W(8))  if_a ();
  lvds_deser_align_if #(.DATA_W(8))  if_b ();
  lvds_deser_align_if #(.DATA_W(10)) if_c ();

  assign if_a.lvds_in = din;
  assign if_b.lvds_in = din;
  assign if_c.lvds_in = din;
  assign if_a.resync  = rsync;
  assign if_b.resync  = rsync;
  assign if_c.resync  = rsync;

  lvds_deser_align #(.DATA_W(8), .LSB_FIRST(1'b1), .SYNC_WORD(8'hA5), .LOCK_CNT(3)) dut_a (
    .lvds_clk(clk), .rst_n(rst_n), .bus(if_a));
  lvds_deser_align #(.DATA_W(8), .LSB_FIRST(1'b0), .SYNC_WORD(8'hA5), .LOCK_CNT(3)) dut_b (
    .lvds_clk(clk), .rst_n(rst_n), .bus(if_b));
  lvds_deser_align #(.DATA_W(10), .LSB_FIRST(1'b0), .SYNC_WORD(10'h2A5), .LOCK_CNT(3)) dut_c (
    .lvds_clk(clk), .rst_n(rst_n), .bus(if_c));

  always @(negedge clk) begin
    if (if_a.out_valid) begin
      qa_w.push_back(10'(if_a.lvds_out));
      qa_t.push_back(cyc);
    end
    if (if_b.out_valid) qb_w.push_back(10'(if_b.lvds_out));
    if (if_c.out_valid) begin
      qc_w.push_back(if_c.lvds_out);
      qc_t.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [9:0] val, input int w, input bit lsb);
    for (int i = 0; i < w; i++) send_bit(lsb ? val[i] : val[w-1-i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din   = 1'b0;
    rsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    qa_w.delete(); qa_t.delete(); qb_w.delete(); qc_w.delete(); qc_t.delete();
  endtask

  function automatic logic [9:0] qa_at(input int idx);
    return (qa_w.size() > idx) ? qa_w[idx] : 10'h3FF;
  endfunction

  initial begin
    logic [7:0] w8;

    // reset state
    do_reset();
    check("rst_lvds_out", 32'(if_a.lvds_out), 32'h0);
    check("rst_out_valid", 32'(if_a.out_valid), 32'h0);
    check("rst_locked", 32'(if_a.locked), 32'h0);
    check("rst_locked_c", 32'(if_c.locked), 32'h0);

    // basic lock with 3 junk bits
    send_zeros(3);
    repeat (3) send_word(10'hA5, 8, 1'b1);
    check("t1_locked_before", 32'(if_a.locked), 32'h0);
    w8 = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      send_bit(w8[i]);
      if (i == 0) check("t1_locked_rise", 32'(if_a.locked), 32'h1);
    end
    t_end = cyc;
    send_word(10'hF0, 8, 1'b1);
    send_zeros(4);
    check("t1_count", 32'(qa_w.size()), 32'd2);
    check("t1_word0", 32'(qa_at(0)), 32'h3C);
    check("t1_word1", 32'(qa_at(1)), 32'hF0);
    check("t1_latency", 32'((qa_t.size() > 0) ? qa_t[0] : -1), 32'(t_end + 1));
    check("t1_spacing", 32'((qa_t.size() > 1) ? qa_t[1] - qa_t[0] : -1), 32'd8);

    // any-phase lock
    for (int o = 0; o < 8; o++) begin
      do_reset();
      send_zeros(o);
      repeat (3) send_word(10'hA5, 8, 1'b1);
      send_word(10'h3C, 8, 1'b1);
      send_word(10'hF0, 8, 1'b1);
      send_zeros(4);
      check($sformatf("t2_count_o%0d", o), 32'(qa_w.size()), 32'd2);
      check($sformatf("t2_word0_o%0d", o), 32'(qa_at(0)), 32'h3C);
      check($sformatf("t2_word1_o%0d", o), 32'(qa_at(1)), 32'hF0);
    end

    // verify abort on a bad boundary word
    do_reset();
    send_zeros(2);
    send_word(10'hA5, 8, 1'b1);
    send_word(10'hA5, 8, 1'b1);
    send_word(10'h5A, 8, 1'b1);
    check("t3_not_locked", 32'(if_a.locked), 32'h0);
    repeat (3) send_word(10'hA5, 8, 1'b1);
    send_word(10'h11, 8, 1'b1);
    send_zeros(4);
    check("t3_count", 32'(qa_w.size()), 32'd1);
    check("t3_word0", 32'(qa_at(0)), 32'h11);
    check("t3_locked", 32'(if_a.locked), 32'h1);

    // MSB-first, 8 bits
    do_reset();
    send_zeros(1);
    repeat (3) send_word(10'hA5, 8, 1'b0);
    send_word(10'hC3, 8, 1'b0);
    send_zeros(2);
    check("t4_b_count", 32'(qb_w.size()), 32'd1);
    check("t4_b_word0", 32'((qb_w.size() > 0) ? qb_w[0] : 10'h3FF), 32'hC3);
    check("t4_b_locked", 32'(if_b.locked), 32'h1);

    // MSB-first, 10 bits
    do_reset();
    send_zeros(5);
    repeat (3) send_word(10'h2A5, 10, 1'b0);
    send_word(10'h1C3, 10, 1'b0);
    send_word(10'h31E, 10, 1'b0);
    send_zeros(3);
    check("t4_c_count", 32'(qc_w.size()), 32'd2);
    check("t4_c_word0", 32'((qc_w.size() > 0) ? qc_w[0] : 10'h3FF), 32'h1C3);
    check("t4_c_word1", 32'((qc_w.size() > 1) ? qc_w[1] : 10'h3FF), 32'h31E);
    check("t4_c_spacing", 32'((qc_t.size() > 1) ? qc_t[1] - qc_t[0] : -1), 32'd10);

    // resync on a word-complete cycle while locked
    do_reset();
    send_zeros(1);
    repeat (3) send_word(10'hA5, 8, 1'b1);
    send_word(10'h3C, 8, 1'b1);
    send_word(10'h77, 8, 1'b1);
    rsync = 1'b1;
    send_bit(1'b0);
    rsync = 1'b0;
    check("t5_valid_at_resync", 32'(if_a.out_valid), 32'h0);
    check("t5_locked_drop", 32'(if_a.locked), 32'h0);
    check("t5_out_hold", 32'(if_a.lvds_out), 32'h3C);
    repeat (3) send_word(10'hA5, 8, 1'b1);
    check("t5_locked_before", 32'(if_a.locked), 32'h0);
    send_word(10'h96, 8, 1'b1);
    send_zeros(3);
    check("t5_relocked", 32'(if_a.locked), 32'h1);
    check("t5_count", 32'(qa_w.size()), 32'd2);
    check("t5_word1", 32'(qa_at(1)), 32'h96);

    // reset mid-word while locked
    do_reset();
    send_zeros(1);
    repeat (3) send_word(10'hA5, 8, 1'b1);
    send_word(10'h3C, 8, 1'b1);
    send_zeros(4);
    check("t6_pre_count", 32'(qa_w.size()), 32'd1);
    rst_n = 1'b0;
    send_bit(1'b1);
    rst_n = 1'b1;
    check("t6_rst_out", 32'(if_a.lvds_out), 32'h0);
    check("t6_rst_valid", 32'(if_a.out_valid), 32'h0);
    check("t6_rst_locked", 32'(if_a.locked), 32'h0);
    qa_w.delete(); qa_t.delete();
    repeat (3) send_word(10'hA5, 8, 1'b1);
    send_word(10'h69, 8, 1'b1);
    send_zeros(3);
    check("t6_count", 32'(qa_w.size()), 32'd1);
    check("t6_word0", 32'(qa_at(0)), 32'h69);
    check("t6_locked", 32'(if_a.locked), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
